// File: rtl/fcmp_arbiter_ctrl_if.sv
// Request/response bundle for the shared FCMP unit: two requesters in, one response out.
interface fcmp_arbiter_ctrl_if #(parameter int TAG_W = 4);
  logic             req0_valid, req0_ready;
  logic [2:0]       req0_op;
  logic [32:0]      req0_a, req0_b;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready;
  logic [2:0]       req1_op;
  logic [32:0]      req1_a, req1_b;
  logic [TAG_W-1:0] req1_tag;
  logic             resp_valid, resp_ready, resp_src;
  logic [TAG_W-1:0] resp_tag;
  logic [32:0]      resp_data;
  logic [4:0]       resp_exc;
  logic             flags_clr;
  logic [4:0]       flags_acc;
  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
    input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
    input  resp_ready, flags_clr,
    output req0_ready, req1_ready, resp_valid, resp_src, resp_tag,
    output resp_data, resp_exc, flags_acc, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_tag,
    output req1_valid, req1_op, req1_a, req1_b, req1_tag,
    output resp_ready, flags_clr,
    input  req0_ready, req1_ready, resp_valid, resp_src, resp_tag,
    input  resp_data, resp_exc, flags_acc, busy
  );
endinterface

// File: rtl/fcmp_arbiter_ctrl.sv
// Two-requester arbiter around one recoded-F32 comparator, 2-stage pipe with backpressure
// and sticky exception flags.
module fcmp_arbiter_ctrl #(
  parameter int TAG_W = 4,
  parameter bit RR_EN = 1'b1
) (
  input logic             clock,
  input logic             reset_n,
  fcmp_arbiter_ctrl_if.slave bus
);
  localparam logic [2:0]  OP_FEQ = 3'd0, OP_FLT = 3'd1, OP_FLE = 3'd2,
                          OP_FMIN = 3'd3, OP_FMAX = 3'd4;
  localparam logic [32:0] CANON_NAN = 33'h0_E040_0000;

  typedef struct packed {
    logic [2:0]       op;
    logic [32:0]      a;
    logic [32:0]      b;
    logic [TAG_W-1:0] tag;
    logic             src;
  } s1_t;

  s1_t              s1;
  logic             s1_valid, s2_valid, rr_ptr;
  logic             adv1, adv2, grant0, grant1, resp_hs;
  logic             resp_src;
  logic [TAG_W-1:0] resp_tag;
  logic [32:0]      resp_data, res_data;
  logic [4:0]       resp_exc, res_exc, flags_acc;

  assign adv2    = !s2_valid | bus.resp_ready;
  assign adv1    = !s1_valid | adv2;
  assign grant0  = bus.req0_valid & (!bus.req1_valid | !RR_EN | !rr_ptr);
  assign grant1  = bus.req1_valid & !grant0;
  assign resp_hs = s2_valid & bus.resp_ready;

  assign bus.req0_ready = adv1 & grant0;
  assign bus.req1_ready = adv1 & grant1;
  assign bus.resp_valid = s2_valid;
  assign bus.resp_src   = resp_src;
  assign bus.resp_tag   = resp_tag;
  assign bus.resp_data  = resp_data;
  assign bus.resp_exc   = resp_exc;
  assign bus.flags_acc  = flags_acc;
  assign bus.busy       = s1_valid | s2_valid;

  // Comparator on recoded operands: exp[8:6] = 000 zero, 110 inf, 111 NaN.
  logic       sign_a, sign_b, nan_a, nan_b, snan_a, snan_b, signaling;
  logic       both_zero, both_inf, eq_exps, lt_mags, eq_mags, ordered;
  logic       lt, eq, invalid;
  logic [8:0] exp_a, exp_b;

  always_comb begin
    sign_a    = s1.a[32];
    sign_b    = s1.b[32];
    exp_a     = s1.a[31:23];
    exp_b     = s1.b[31:23];
    nan_a     = exp_a[8:6] == 3'b111;
    nan_b     = exp_b[8:6] == 3'b111;
    snan_a    = nan_a & !s1.a[22];
    snan_b    = nan_b & !s1.b[22];
    both_zero = (exp_a[8:6] == 3'b000) & (exp_b[8:6] == 3'b000);
    both_inf  = (exp_a[8:6] == 3'b110) & (exp_b[8:6] == 3'b110);
    eq_exps   = exp_a == exp_b;
    lt_mags   = (exp_a < exp_b) | (eq_exps & (s1.a[22:0] < s1.b[22:0]));
    eq_mags   = eq_exps & (s1.a[22:0] == s1.b[22:0]);
    ordered   = !nan_a & !nan_b;
    signaling = (s1.op == OP_FLT) | (s1.op == OP_FLE);
    lt = ordered & !both_zero & ((sign_a & !sign_b) |
         (!both_inf & ((sign_a & !lt_mags & !eq_mags) | (!sign_b & lt_mags))));
    eq = ordered & (both_zero | ((sign_a == sign_b) & (both_inf | eq_mags)));
    invalid = snan_a | snan_b | (signaling & !ordered);
  end

  // Sign tie-break on eq orders -0 below +0 for FMIN/FMAX.
  always_comb begin
    res_data = '0;
    res_exc  = '0;
    case (s1.op)
      OP_FEQ: res_data = {32'b0, eq};
      OP_FLT: res_data = {32'b0, lt};
      OP_FLE: res_data = {32'b0, lt | eq};
      OP_FMIN, OP_FMAX: begin
        if (nan_a & nan_b)  res_data = CANON_NAN;
        else if (nan_a)     res_data = s1.b;
        else if (nan_b)     res_data = s1.a;
        else if (s1.op == OP_FMIN)
          res_data = (lt | (eq & sign_a)) ? s1.a : s1.b;
        else
          res_data = ((!lt & !eq) | (eq & !sign_a)) ? s1.a : s1.b;
      end
      default: res_data = '0;
    endcase
    if (s1.op <= OP_FMAX) res_exc = {invalid, 4'b0};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1        <= '0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      rr_ptr    <= 1'b0;
      resp_src  <= 1'b0;
      resp_tag  <= '0;
      resp_data <= '0;
      resp_exc  <= '0;
      flags_acc <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= grant0 | grant1;
        if (grant0) begin
          s1     <= '{op: bus.req0_op, a: bus.req0_a, b: bus.req0_b, tag: bus.req0_tag, src: 1'b0};
          rr_ptr <= 1'b1;
        end else if (grant1) begin
          s1     <= '{op: bus.req1_op, a: bus.req1_a, b: bus.req1_b, tag: bus.req1_tag, src: 1'b1};
          rr_ptr <= 1'b0;
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          resp_src  <= s1.src;
          resp_tag  <= s1.tag;
          resp_data <= res_data;
          resp_exc  <= res_exc;
        end
      end
      // A clear racing a handshake keeps the incoming flag.
      if (bus.flags_clr)  flags_acc <= resp_hs ? resp_exc : 5'b0;
      else if (resp_hs)   flags_acc <= flags_acc | resp_exc;
    end
  end
endmodule

// File: tb/tb_fcmp_arbiter_ctrl.sv
// Scoreboard bench for fcmp_arbiter_ctrl: directed requests push expectations, a monitor pops on response.
module tb_fcmp_arbiter_ctrl;
  localparam logic [32:0] ONE  = 33'h0_3F80_0000, TWO  = 33'h0_4000_0000;
  localparam logic [32:0] QNAN = 33'h0_E040_0000, SNAN = 33'h0_E000_0001;
  localparam logic [32:0] PZ   = 33'h0_0000_0000, NZ   = 33'h1_0000_0000;

  typedef struct {
    logic        src;
    logic [3:0]  tag;
    logic [32:0] data;
    logic [4:0]  exc;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  fcmp_arbiter_ctrl_if #(.TAG_W(4)) ifc ();
  fcmp_arbiter_ctrl #(.TAG_W(4), .RR_EN(1'b1)) dut (.clock(clock), .reset_n(reset_n), .bus(ifc));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && ifc.resp_valid && ifc.resp_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got tag %0h expected none", ifc.resp_tag);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_src",  64'(ifc.resp_src),  64'(e.src));
        chk("resp_tag",  64'(ifc.resp_tag),  64'(e.tag));
        chk("resp_data", 64'(ifc.resp_data), 64'(e.data));
        chk("resp_exc",  64'(ifc.resp_exc),  64'(e.exc));
      end
    end
  end

  task automatic issue(input int r, input logic [2:0] op, input logic [32:0] a, input logic [32:0] b,
                       input logic [3:0] tag, input logic [32:0] ed, input logic [4:0] ee);
    bit done;
    done = 1'b0;
    if (r == 0) begin
      ifc.req0_op = op; ifc.req0_a = a; ifc.req0_b = b; ifc.req0_tag = tag; ifc.req0_valid = 1'b1;
    end else begin
      ifc.req1_op = op; ifc.req1_a = a; ifc.req1_b = b; ifc.req1_tag = tag; ifc.req1_valid = 1'b1;
    end
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clock);
      if ((r == 0) ? ifc.req0_ready : ifc.req1_ready) begin
        q.push_back('{src: 1'(r), tag: tag, data: ed, exc: ee});
        done = 1'b1;
      end
    end
    if (!done) chk("issue_timeout", 64'd0, 64'd1);
    @(posedge clock); #1;
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 50) begin
      @(negedge clock);
      k++;
    end
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
    @(posedge clock); #1;
  endtask

  task automatic check_reset_state();
    chk("rst_resp_valid", 64'(ifc.resp_valid), 64'd0);
    chk("rst_busy",       64'(ifc.busy),       64'd0);
    chk("rst_flags",      64'(ifc.flags_acc),  64'd0);
    chk("rst_data",       64'(ifc.resp_data),  64'd0);
    chk("rst_tag",        64'(ifc.resp_tag),   64'd0);
  endtask

  initial begin
    int acc;
    ifc.req0_valid = 1'b0; ifc.req0_op = '0; ifc.req0_a = '0; ifc.req0_b = '0; ifc.req0_tag = '0;
    ifc.req1_valid = 1'b0; ifc.req1_op = '0; ifc.req1_a = '0; ifc.req1_b = '0; ifc.req1_tag = '0;
    ifc.resp_ready = 1'b1;
    ifc.flags_clr  = 1'b0;
    #12;
    check_reset_state();
    reset_n = 1'b1;
    @(posedge clock); #1;

    // FLT 1.0 < 2.0 with exact 2-cycle latency
    issue(0, 3'd1, ONE, TWO, 4'd5, 33'd1, 5'h00);
    @(negedge clock);
    chk("lat_cycle1", 64'(ifc.resp_valid), 64'd0);
    @(negedge clock);
    chk("lat_cycle2", 64'(ifc.resp_valid), 64'd1);
    drain();

    // NaN compares and sticky flags
    issue(1, 3'd0, QNAN, ONE, 4'd1, 33'd0, 5'h00);
    issue(0, 3'd1, QNAN, ONE, 4'd2, 33'd0, 5'h10);
    drain();
    chk("flags_after_nv", 64'(ifc.flags_acc), 64'h10);
    ifc.flags_clr = 1'b1;
    @(posedge clock); #1;
    ifc.flags_clr = 1'b0;
    chk("flags_after_clr", 64'(ifc.flags_acc), 64'h00);

    // signed zeros, NaN selection, FLE, reserved op (back to back)
    issue(0, 3'd3, PZ, NZ, 4'd3, NZ, 5'h00);
    issue(0, 3'd4, PZ, NZ, 4'd4, PZ, 5'h00);
    issue(0, 3'd4, SNAN, ONE, 4'd6, ONE, 5'h10);
    issue(0, 3'd4, QNAN, SNAN, 4'd7, QNAN, 5'h10);
    issue(1, 3'd3, QNAN, QNAN, 4'd8, QNAN, 5'h00);
    issue(0, 3'd2, TWO, TWO, 4'd9, 33'd1, 5'h00);
    issue(1, 3'd5, ONE, TWO, 4'd10, 33'd0, 5'h00);
    drain();
    chk("flags_accum", 64'(ifc.flags_acc), 64'h10);

    // reset again so the round-robin pointer starts at 0
    reset_n = 1'b0;
    #2;
    check_reset_state();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // both requesters valid: grants alternate, responses in issue order
    ifc.req0_op = 3'd1; ifc.req0_a = ONE; ifc.req0_b = TWO; ifc.req0_tag = 4'd0; ifc.req0_valid = 1'b1;
    ifc.req1_op = 3'd2; ifc.req1_a = TWO; ifc.req1_b = ONE; ifc.req1_tag = 4'd1; ifc.req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("rr_ready0", 64'(ifc.req0_ready), 64'((i % 2) == 0));
      chk("rr_ready1", 64'(ifc.req1_ready), 64'((i % 2) == 1));
      q.push_back('{src: 1'(i % 2), tag: 4'(i), data: ((i % 2) == 0) ? 33'd1 : 33'd0, exc: 5'h00});
      @(posedge clock); #1;
      if ((i % 2) == 0) ifc.req0_tag = 4'(i + 2);
      else              ifc.req1_tag = 4'(i + 2);
    end
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    drain();

    // stall: pipe holds two entries, head response stays stable
    ifc.resp_ready = 1'b0;
    ifc.req0_op = 3'd4; ifc.req0_a = ONE; ifc.req0_b = TWO; ifc.req0_tag = 4'd3; ifc.req0_valid = 1'b1;
    ifc.req1_op = 3'd3; ifc.req1_a = ONE; ifc.req1_b = TWO; ifc.req1_tag = 4'd4; ifc.req1_valid = 1'b1;
    acc = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clock);
      if (ifc.req0_ready | ifc.req1_ready) acc++;
      if (j >= 2) begin
        chk("stall_valid", 64'(ifc.resp_valid), 64'd1);
        chk("stall_data",  64'(ifc.resp_data),  64'(TWO));
        chk("stall_tag",   64'(ifc.resp_tag),   64'd3);
        chk("stall_src",   64'(ifc.resp_src),   64'd0);
      end
      @(posedge clock); #1;
    end
    chk("stall_accepts", 64'(acc), 64'd2);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(ifc.resp_valid), 64'd0);
    chk("midrst_busy",  64'(ifc.busy),       64'd0);
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
